// File: rtl/sample_frame_ctrl.sv
// Ping-pong frame controller: ADC samples fill one RAM bank while the FFT streams the other.
// Define BIT_REVERSE_EN to read frames in bit-reversed (decimation-in-time) order.
module sample_frame_ctrl #(
    parameter int DATA_W     = 18,
    parameter int FRAME_LOG2 = 9
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  rd_start,
    output logic                  frame_ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  ram_weA,
    output logic [FRAME_LOG2:0]   ram_addrA,
    output logic [DATA_W-1:0]     ram_dinA,
    output logic                  ram_weB,
    output logic [FRAME_LOG2:0]   ram_addrB,
    output logic [DATA_W-1:0]     ram_dinB,
    input  logic [DATA_W-1:0]     ram_doutB
);

    typedef enum logic {W_FILL, W_STALL} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rState_t;

    wState_t                 wState;
    rState_t                 rState;
    logic                    wrBank;
    logic [FRAME_LOG2-1:0]   wrCnt;
    logic                    rdBank;
    logic [FRAME_LOG2-1:0]   rdCnt;
    logic [1:0]              bankFull;
    logic                    addrValid;
    logic                    issueQ;

    logic                    setFull;
    logic                    clrFull;
    logic                    clrSame;
    logic                    clrOther;
    logic                    drop;
    logic [1:0]              setMask;
    logic [1:0]              clrMask;

    function automatic logic [FRAME_LOG2-1:0] idx(input logic [FRAME_LOG2-1:0] cnt);
        logic [FRAME_LOG2-1:0] r;
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < FRAME_LOG2; i++) r[i] = cnt[FRAME_LOG2-1-i];
`else
        r = cnt;
`endif
        return r;
    endfunction

    assign setFull  = (wState == W_FILL) && sample_valid && (wrCnt == '1);
    assign clrFull  = (rState == R_DRAIN);
    assign clrSame  = clrFull && (rdBank == wrBank);
    assign clrOther = clrFull && (rdBank != wrBank);
    assign drop     = (wState == W_STALL) && sample_valid;
    assign setMask  = setFull ? (wrBank ? 2'b10 : 2'b01) : 2'b00;
    assign clrMask  = clrFull ? (rdBank ? 2'b10 : 2'b01) : 2'b00;

    assign frame_ready = bankFull[rdBank] && (rState == R_IDLE);
    assign rd_data     = ram_doutB;
    assign ram_weB     = 1'b0;
    assign ram_dinB    = '0;

    // Bank occupancy: writer marks a bank full, reader frees it at frame end
    always_ff @(posedge Clk) begin
        if (!reset) begin
            bankFull <= 2'b00;
        end else begin
            bankFull <= (bankFull & ~clrMask) | setMask;
        end
    end

    // Capture side: write samples into the fill bank, stall while both banks are full
    always_ff @(posedge Clk) begin
        if (!reset) begin
            wState    <= W_FILL;
            wrBank    <= 1'b0;
            wrCnt     <= '0;
            ram_weA   <= 1'b0;
            ram_addrA <= '0;
            ram_dinA  <= '0;
        end else begin
            ram_weA <= 1'b0;
            unique case (wState)
                W_FILL: begin
                    if (sample_valid) begin
                        ram_weA   <= 1'b1;
                        ram_addrA <= {wrBank, wrCnt};
                        ram_dinA  <= sample_in;
                        wrCnt     <= wrCnt + 1'b1;
                        if (wrCnt == '1) begin
                            wrBank <= ~wrBank;
                            if (bankFull[~wrBank] && !clrOther) wState <= W_STALL;
                        end
                    end
                end
                W_STALL: begin
                    if (clrSame) wState <= W_FILL;
                end
                default: wState <= W_FILL;
            endcase
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear
    always_ff @(posedge Clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // FFT side: issue one address per cycle, data returns two cycles after issue
    always_ff @(posedge Clk) begin
        if (!reset) begin
            rState    <= R_IDLE;
            rdBank    <= 1'b0;
            rdCnt     <= '0;
            addrValid <= 1'b0;
            issueQ    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            ram_addrB <= '0;
        end else begin
            issueQ   <= addrValid;
            rd_valid <= issueQ;
            unique case (rState)
                R_IDLE: begin
                    if (rd_start && bankFull[rdBank]) begin
                        ram_addrB <= {rdBank, idx('0)};
                        rdCnt     <= FRAME_LOG2'(1);
                        addrValid <= 1'b1;
                        rState    <= R_READ;
                    end
                end
                R_READ: begin
                    if (addrValid) begin
                        if (rdCnt == '0) begin
                            addrValid <= 1'b0;
                        end else begin
                            ram_addrB <= {rdBank, idx(rdCnt)};
                            rdCnt     <= rdCnt + 1'b1;
                        end
                    end else if (issueQ) begin
                        rd_last <= 1'b1;
                        rState  <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    rd_last <= 1'b0;
                    rdBank  <= ~rdBank;
                    rState  <= R_IDLE;
                end
                default: rState <= R_IDLE;
            endcase
        end
    end

endmodule
